// File: rtl/spi_pkg.sv
// Shared SPI types for the bridge: state encoding, default word width and a
// counter-width helper.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Width of a down-counter that must hold values 0..n-1.
    function automatic int spi_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// sclk half-period divider: emits a one-cycle tick every CLK_DIV enabled
// cycles, restarting from a full period whenever clr_i is asserted.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic rd_clk_i,
    input  logic rd_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = spi_cnt_w(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == '0);

    always_ff @(posedge rd_clk_i) begin
        if (rd_rst_i || clr_i) begin
            cnt_q <= RELOAD;
        end else if (en_i) begin
            if (cnt_q == '0) cnt_q <= RELOAD;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 transmit SPI master fed by a FWFT FIFO. Define SPI_MASTER_BURST_EN
// to chain queued words inside one cs_n frame instead of framing each word.
//   state | meaning
//   IDLE  | cs_n high, waiting for a FIFO word
//   SETUP | cs_n low, MSB on mosi, CS_SETUP cycles before the first low half
//   SHIFT | sclk toggling, one bit per period
//   HOLD  | sclk low, cs_n still low for CS_HOLD cycles
//   GAP   | cs_n high for CS_HOLD cycles before the next word may start
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rd_en,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              busy,
    output logic              done
);

    localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TW   = spi_cnt_w(TMAX);
    localparam int BW   = spi_cnt_w(DATA_W + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BIT_LD   = BW'(DATA_W);

    spi_state_e        state_q;
    logic [TW-1:0]     tmr_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic              sclk_q;
    logic              cs_n_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;

    logic div_clr;
    logic div_en;
    logic tick;

    // Restart the divider on SHIFT entry so every word opens with a full low half.
    assign div_clr = (state_q == SETUP) && (tmr_q == '0);
    assign div_en  = (state_q == SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .rd_clk_i (rd_clk),
        .rd_rst_i (rd_rst),
        .clr_i    (div_clr),
        .en_i     (div_en),
        .tick_o   (tick)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rd_empty) begin
                        rd_en_q <= 1'b1;
                        shreg_q <= tx_data;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        tmr_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_q == '0) begin
                        bit_q   <= BIT_LD;
                        state_q <= SHIFT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q - 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == '0) begin
                                done_q <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                                if (!rd_empty) begin
                                    rd_en_q <= 1'b1;
                                    shreg_q <= tx_data;
                                    bit_q   <= BIT_LD;
                                end else begin
                                    tmr_q   <= HOLD_LD;
                                    state_q <= HOLD;
                                end
`else
                                tmr_q   <= HOLD_LD;
                                state_q <= HOLD;
`endif
                            end else begin
                                shreg_q <= shreg_q << 1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tmr_q == '0) begin
                        cs_n_q  <= 1'b1;
                        shreg_q <= '0;
                        tmr_q   <= HOLD_LD;
                        state_q <= GAP;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // mosi is the shift register MSB, so it only moves on falling ticks or frame end.
    assign mosi  = shreg_q[DATA_W-1];
    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign rd_en = rd_en_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: FIFO model, mode-0 receiver model, timing
// capture and protocol monitor. Burst expectations follow SPI_MASTER_BURST_EN.
module tb_spi_master;

    localparam int DATA_W   = 8;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic              rd_clk = 1'b0;
    logic              rd_rst = 1'b1;
    logic              rd_empty = 1'b1;
    logic [DATA_W-1:0] tx_data = '0;
    logic              rd_en;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              busy;
    logic              done;

    always #5 rd_clk = ~rd_clk;

    spi_master #(
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst   (rd_rst),
        .rd_empty (rd_empty),
        .tx_data  (tx_data),
        .rd_en    (rd_en),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    logic [DATA_W-1:0] fifo_q[$];
    int exp_q[$];
    int rx_q[$];
    int done_log[$], rden_log[$], csfall_log[$], csrise_log[$], rise1_log[$], rises_log[$];
    int cyc = 0;
    int lastfall = -1;
    int rises_cur = 0;
    int rx_bits = 0;
    int mosi_viol = 0;
    int rden_viol = 0;
    logic [DATA_W-1:0] rx_sh = '0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

    // FIFO owner, receiver model and protocol monitor, all sampled mid-cycle.
    always @(negedge rd_clk) begin
        cyc++;
        if (rd_en && rd_empty) rden_viol++;
        if (sclk && (mosi !== p_mosi)) mosi_viol++;
        if (p_cs && !cs_n) begin
            csfall_log.push_back(cyc);
            rises_cur = 0;
            rx_bits   = 0;
        end
        if (!p_cs && cs_n) begin
            csrise_log.push_back(cyc);
            rises_log.push_back(rises_cur);
        end
        if (!p_sclk && sclk) begin
            if (rises_cur == 0) rise1_log.push_back(cyc);
            rises_cur++;
            if (!cs_n) begin
                rx_sh = {rx_sh[DATA_W-2:0], mosi};
                rx_bits++;
                if (rx_bits == DATA_W) begin
                    rx_q.push_back(int'(rx_sh));
                    rx_bits = 0;
                end
            end
        end
        if (p_sclk && !sclk) lastfall = cyc;
        if (done) done_log.push_back(cyc);
        if (rd_en) begin
            rden_log.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        rd_empty = (fifo_q.size() == 0);
        tx_data  = rd_empty ? '0 : fifo_q[0];
        p_cs   = cs_n;
        p_sclk = sclk;
        p_mosi = mosi;
    end

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(int'(w));
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (csrise_log.size() < target && n < 2000) begin
            @(negedge rd_clk); #1;
            n++;
        end
        check_eq({tag, "_frames_done"}, int'(csrise_log.size() >= target), 1);
        repeat (10) begin @(negedge rd_clk); #1; end
        check_eq({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic drain_rx(input string tag);
        while (rx_q.size() > 0) begin
            if (exp_q.size() == 0) check_eq({tag, "_extra_byte"}, rx_q.pop_front(), -1);
            else                   check_eq({tag, "_rx_byte"}, rx_q.pop_front(), exp_q.pop_front());
        end
        check_eq({tag, "_missing_bytes"}, exp_q.size(), 0);
    endtask

    int fb, rb, db, eb, r1b, p, bad, n;

    initial begin
        rd_rst = 1'b1;
        repeat (3) @(negedge rd_clk);
        #1;
        check_eq("rst_cs_n",  int'(cs_n),  1);
        check_eq("rst_sclk",  int'(sclk),  0);
        check_eq("rst_mosi",  int'(mosi),  0);
        check_eq("rst_rd_en", int'(rd_en), 0);
        check_eq("rst_busy",  int'(busy),  0);
        check_eq("rst_done",  int'(done),  0);
        rd_rst = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge rd_clk); #1;
            if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        check_eq("idle_quiet", bad, 0);

        // Single word
        fb = csfall_log.size(); rb = csrise_log.size(); db = done_log.size();
        eb = rden_log.size();   r1b = rise1_log.size();
        push_word(8'hA5);
        wait_frames(rb + 1, "single");
        p = at(rden_log, eb);
        check_eq("single_pops",      rden_log.size() - eb, 1);
        check_eq("single_cs_fall",   at(csfall_log, fb), p);
        check_eq("single_rise1",     at(rise1_log, r1b), p + CS_SETUP + CLK_DIV);
        check_eq("single_done_cnt",  done_log.size() - db, 1);
        check_eq("single_done_fall", at(done_log, db), lastfall);
        check_eq("single_cs_rise",   at(csrise_log, rb), lastfall + CS_HOLD);
        check_eq("single_rises",     at(rises_log, rb), DATA_W);
        drain_rx("single");

        // Two queued words
        fb = csfall_log.size(); rb = csrise_log.size(); db = done_log.size();
        eb = rden_log.size();
        push_word(8'h3C);
        push_word(8'hC3);
`ifdef SPI_MASTER_BURST_EN
        wait_frames(rb + 1, "burst");
        check_eq("burst_frames",   csrise_log.size() - rb, 1);
        check_eq("burst_rises",    at(rises_log, rb), 2 * DATA_W);
        check_eq("burst_pop_done", at(rden_log, eb + 1), at(done_log, db));
        check_eq("burst_done_cnt", done_log.size() - db, 2);
        drain_rx("burst");
`else
        wait_frames(rb + 2, "pair");
        check_eq("pair_frames",   csrise_log.size() - rb, 2);
        check_eq("pair_gap_min",  int'((at(csfall_log, fb + 1) - at(csrise_log, rb)) >= CS_HOLD), 1);
        check_eq("pair_rises",    at(rises_log, rb + 1), DATA_W);
        check_eq("pair_done_cnt", done_log.size() - db, 2);
        drain_rx("pair");
`endif

        // Reset during a transfer
        db = done_log.size(); eb = rden_log.size();
        push_word(8'hFF);
        n = 0;
        while (!(rises_cur == 4 && cs_n === 1'b0) && n < 500) begin
            @(negedge rd_clk); #1;
            n++;
        end
        check_eq("abort_reached_rise4", int'(n < 500), 1);
        rd_rst = 1'b1;
        @(negedge rd_clk); #1;
        check_eq("abort_cs_n",  int'(cs_n),  1);
        check_eq("abort_sclk",  int'(sclk),  0);
        check_eq("abort_busy",  int'(busy),  0);
        check_eq("abort_rd_en", int'(rd_en), 0);
        rd_rst = 1'b0;
        repeat (30) begin @(negedge rd_clk); #1; end
        check_eq("abort_no_done", done_log.size() - db, 0);
        check_eq("abort_one_pop", rden_log.size() - eb, 1);
        check_eq("abort_no_rx",   rx_q.size(), 0);
        exp_q.delete();

        check_eq("proto_mosi_stable",  mosi_viol, 0);
        check_eq("proto_rden_nonempty", rden_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
